// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE/MEM boundary of the execute stage: decoded operands in,
// pipeline-register contents and the upstream stall out.
interface exe_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             evalid;
  logic             ewreg;
  logic             em2reg;
  logic             ewmem;
  logic [3:0]       ealuc;
  logic             ealuimm;
  logic [4:0]       emux;
  logic [WIDTH-1:0] eqa;
  logic [WIDTH-1:0] eqb;
  logic [WIDTH-1:0] esignextendimm;

  logic             mvalid;
  logic             mwreg;
  logic             mm2reg;
  logic             mwmem;
  logic [4:0]       mmux;
  logic [WIDTH-1:0] malu;
  logic [WIDTH-1:0] mqb;
  logic             estall;

  // master: the ID/EXE side that issues instructions and watches the stall
  modport master (
    output evalid, ewreg, em2reg, ewmem, ealuc, ealuimm, emux,
           eqa, eqb, esignextendimm,
    input  mvalid, mwreg, mm2reg, mwmem, mmux, malu, mqb, estall
  );

  modport slave (
    input  evalid, ewreg, em2reg, ewmem, ealuc, ealuimm, emux,
           eqa, eqb, esignextendimm,
    output mvalid, mwreg, mm2reg, mwmem, mmux, malu, mqb, estall
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: operand-B select, single-cycle ALU, iterative shift-add
// multiply, and the EXE/MEM pipeline register.
module exe_stage #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  pipe
);

  localparam int            CW       = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] prod_d;

  // instruction held aside while the multiplier iterates
  logic             lat_wreg_q;
  logic             lat_m2reg_q;
  logic             lat_wmem_q;
  logic [4:0]       lat_mux_q;
  logic [WIDTH-1:0] lat_qb_q;

  logic             mvalid_q;
  logic             mwreg_q;
  logic             mm2reg_q;
  logic             mwmem_q;
  logic [4:0]       mmux_q;
  logic [WIDTH-1:0] malu_q;
  logic [WIDTH-1:0] mqb_q;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_res;
  logic             is_mul;
  logic             mul_last;

  assign opa      = pipe.eqa;
  assign opb      = pipe.ealuimm ? pipe.esignextendimm : pipe.eqb;
  assign is_mul   = (pipe.ealuc == ALU_MUL);
  assign mul_last = (cnt_q == CNT_LAST);

  always_comb begin
    alu_res = '0;
    case (pipe.ealuc)
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_ADD: alu_res = opa + opb;
      ALU_SUB: alu_res = opa - opb;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_NOR: alu_res = ~(opa | opb);
      default: alu_res = '0;
    endcase
  end

  // one shift-add step; the final step's sum is what gets written out
  assign prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  assign pipe.estall = ((state_q == IDLE) && pipe.evalid && is_mul) ||
                       ((state_q == MUL) && !mul_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      lat_wreg_q  <= 1'b0;
      lat_m2reg_q <= 1'b0;
      lat_wmem_q  <= 1'b0;
      lat_mux_q   <= '0;
      lat_qb_q    <= '0;
      mvalid_q    <= 1'b0;
      mwreg_q     <= 1'b0;
      mm2reg_q    <= 1'b0;
      mwmem_q     <= 1'b0;
      mmux_q      <= '0;
      malu_q      <= '0;
      mqb_q       <= '0;
    end else begin
      // EXE/MEM defaults to a bubble; the branches below override it
      mvalid_q <= 1'b0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      mmux_q   <= '0;
      malu_q   <= '0;
      mqb_q    <= '0;

      case (state_q)
        IDLE: begin
          if (pipe.evalid && is_mul) begin
            mcand_q     <= opa;
            mplier_q    <= opb;
            prod_q      <= '0;
            cnt_q       <= '0;
            lat_wreg_q  <= pipe.ewreg;
            lat_m2reg_q <= pipe.em2reg;
            lat_wmem_q  <= pipe.ewmem;
            lat_mux_q   <= pipe.emux;
            lat_qb_q    <= pipe.eqb;
            state_q     <= MUL;
          end else if (pipe.evalid) begin
            mvalid_q <= 1'b1;
            mwreg_q  <= pipe.ewreg;
            mm2reg_q <= pipe.em2reg;
            mwmem_q  <= pipe.ewmem;
            mmux_q   <= pipe.emux;
            malu_q   <= alu_res;
            mqb_q    <= pipe.eqb;
          end
        end

        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (mul_last) begin
            mvalid_q <= 1'b1;
            mwreg_q  <= lat_wreg_q;
            mm2reg_q <= lat_m2reg_q;
            mwmem_q  <= lat_wmem_q;
            mmux_q   <= lat_mux_q;
            malu_q   <= prod_d;
            mqb_q    <= lat_qb_q;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pipe.mvalid = mvalid_q;
  assign pipe.mwreg  = mwreg_q;
  assign pipe.mm2reg = mm2reg_q;
  assign pipe.mwmem  = mwmem_q;
  assign pipe.mmux   = mmux_q;
  assign pipe.malu   = malu_q;
  assign pipe.mqb    = mqb_q;

endmodule
